// File: rtl/mem_writer_24x8.sv
// 24x8 loadable memory: a burst write controller fills consecutive words from a
// valid/ready byte stream, and a ROM-compatible chip-select read port serves reads.
module mem_writer_24x8 #(
    parameter int DEPTH = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       start,
    input  logic [4:0] start_addr,
    input  logic [4:0] burst_len,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       rd_en,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [1:0] dbg_state
);

    // Handshake: a byte moves on a rising edge where wr_valid & wr_ready are both high;
    // wr_valid may be raised or dropped freely, wr_ready is high only in WRITE with cs=1.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [4:0] LAST_ADDR = 5'(DEPTH - 1);
    localparam logic [4:0] DEPTH_5   = 5'(DEPTH);

    state_t     state_q, state_d;
    logic [4:0] addr_q, addr_d;
    logic [4:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];

    logic req_legal;
    logic handshake;

    assign req_legal = (start_addr < DEPTH_5) && (burst_len != 5'd0) && (burst_len <= DEPTH_5);
    assign handshake = (state_q == WRITE) && cs && wr_valid;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        mem_d   = mem_q;
        case (state_q)
            IDLE: begin
                if (start && cs) begin
                    if (req_legal) begin
                        addr_d  = start_addr;
                        cnt_d   = burst_len;
                        state_d = WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                // cs low stalls the burst: nothing below fires and everything holds.
                if (handshake) begin
                    mem_d[addr_q] = wr_data;
                    addr_d        = (addr_q == LAST_ADDR) ? 5'd0 : addr_q + 5'd1;
                    cnt_d         = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 5'd0;
            cnt_q   <= 5'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign wr_ready  = (state_q == WRITE) && cs;
    assign dbg_state = state_q;

    // Reads see the registered array, so a same-cycle write shows only after its edge.
    assign rd_data = (cs && rd_en && (rd_addr < DEPTH_5)) ? mem_q[rd_addr] : 8'h00;

endmodule
